// File: rtl/gf180mcu_fd_ip_sram__sram512x8m8wm1_wrapper.sv
// Behavioural stand-in for the GF180 512x8 SRAM wrapper: active-low CEN/GWEN/WEN,
// bit-granular write enables, Q registered on read and held across writes.
module gf180mcu_fd_ip_sram__sram512x8m8wm1_wrapper (
`ifdef USE_POWER_PINS
  inout  wire        VDD,
  inout  wire        VSS,
`endif
  input  logic       CLK,
  input  logic       CEN,
  input  logic       GWEN,
  input  logic [7:0] WEN,
  input  logic [8:0] A,
  input  logic [7:0] D,
  output logic [7:0] Q
);

  logic [7:0] r_mem [0:511];
  logic [7:0] r_q;

  // Array write with per-bit enables, or synchronous read into the Q register
  always_ff @(posedge CLK) begin
    if (!CEN) begin
      if (!GWEN) begin
        r_mem[A] <= (r_mem[A] & WEN) | (D & ~WEN);
      end else begin
        r_q <= r_mem[A];
      end
    end
  end

  assign Q = r_q;

endmodule

// File: rtl/sram_banked_gf180.sv
// Banked, byte-maskable SRAM built from GF180 512x8 macros (one per lane per bank),
// with an optional post-reset clear that zeroes every row of every bank in parallel.
module sram_banked_gf180 #(
  parameter  int NUM_LANES = 7,
  parameter  int NUM_BANKS = 1,
  parameter  int ZERO_INIT = 1,
  localparam int ADDR_W    = 9 + $clog2(NUM_BANKS),
  localparam int DW        = 8 * NUM_LANES
) (
`ifdef USE_POWER_PINS
  inout  wire                 VDD,
  inout  wire                 VSS,
`endif
  input  logic                clk,
  input  logic                resetn,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [NUM_LANES-1:0] req_wmask,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DW-1:0]       req_wdata,
  output logic                rsp_valid,
  output logic [DW-1:0]       rsp_rdata,
  output logic                init_done
);

  localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

  localparam logic [0:0] S_INIT = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  localparam logic [0:0] RST_STATE = (ZERO_INIT != 0) ? S_INIT : S_RUN;
  localparam logic       RST_READY = (ZERO_INIT != 0) ? 1'b0 : 1'b1;

  logic [0:0]        r_state;
  logic [8:0]        r_cnt;
  logic              r_ready;
  logic              r_init_done;
  logic              r_rsp_valid;
  logic [BANK_W-1:0] r_bank_q;

  logic              w_acc;
  logic              w_rd_acc;
  logic [BANK_W-1:0] w_bank;
  logic [DW-1:0]     w_q [NUM_BANKS];
  logic [DW-1:0]     w_rdata;

  assign w_acc    = req_valid & r_ready;
  assign w_rd_acc = w_acc & ~req_we;

  if (NUM_BANKS > 1) begin : g_bank_sel
    assign w_bank = req_addr[ADDR_W-1:9];
  end else begin : g_single_bank
    assign w_bank = 1'b0;
  end

  // Clear sequencer: walk rows 0..511 once, then open the request port
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= RST_STATE;
      r_cnt       <= 9'd0;
      r_ready     <= RST_READY;
      r_init_done <= RST_READY;
    end else begin
      case (r_state)
        S_INIT: begin
          if (r_cnt == 9'd511) begin
            r_state     <= S_RUN;
            r_ready     <= 1'b1;
            r_init_done <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 9'd1;
          end
        end
        S_RUN: begin
          r_ready     <= 1'b1;
          r_init_done <= 1'b1;
        end
        default: begin
          r_state     <= RST_STATE;
          r_cnt       <= 9'd0;
          r_ready     <= RST_READY;
          r_init_done <= RST_READY;
        end
      endcase
    end
  end

  // Read response tracking; the bank index steers the output mux one cycle later
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rsp_valid <= 1'b0;
      r_bank_q    <= {BANK_W{1'b0}};
    end else begin
      r_rsp_valid <= w_rd_acc;
      if (w_rd_acc) begin
        r_bank_q <= w_bank;
      end else begin
        r_bank_q <= r_bank_q;
      end
    end
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic                      w_sel;
    logic [NUM_LANES-1:0][7:0] w_q_lanes;

    assign w_sel  = w_acc & (w_bank == BANK_W'(b));
    assign w_q[b] = w_q_lanes;

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
      logic       w_cen;
      logic       w_gwen;
      logic [7:0] w_wen;
      logic [7:0] w_d;
      logic [8:0] w_a;

      // Macro pins: forced clear-write during INIT, otherwise decoded from the request
      always_comb begin
        if (r_state == S_INIT) begin
          w_cen  = 1'b0;
          w_gwen = 1'b0;
          w_wen  = 8'h00;
          w_d    = 8'h00;
          w_a    = r_cnt;
        end else begin
          w_cen  = ~(w_sel & (~req_we | req_wmask[l]));
          w_gwen = ~(w_sel & req_we);
          w_wen  = (w_sel & req_we & req_wmask[l]) ? 8'h00 : 8'hFF;
          w_d    = req_wdata[8*l +: 8];
          w_a    = req_addr[8:0];
        end
      end

      gf180mcu_fd_ip_sram__sram512x8m8wm1_wrapper u_macro (
`ifdef USE_POWER_PINS
        .VDD  (VDD),
        .VSS  (VSS),
`endif
        .CLK  (clk),
        .CEN  (w_cen),
        .GWEN (w_gwen),
        .WEN  (w_wen),
        .A    (w_a),
        .D    (w_d),
        .Q    (w_q_lanes[l])
      );
    end
  end

  // AND-OR bank mux on the registered bank index
  always_comb begin
    w_rdata = {DW{1'b0}};
    for (int b = 0; b < NUM_BANKS; b++) begin
      w_rdata = w_rdata | (w_q[b] & {DW{r_bank_q == BANK_W'(b)}});
    end
  end

  assign req_ready = r_ready;
  assign init_done = r_init_done;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = w_rdata;

endmodule

// File: tb/tb_sram_banked_gf180.sv
// Randomised self-checking bench: a 4-bank cleared instance against a flat memory
// model, plus a 1-bank instance without the clear sequence.
module tb_sram_banked_gf180;

  localparam int NL = 7;

  logic        clk;

  logic        resetn_a, a_valid, a_we, a_ready, a_rsp_valid, a_init_done;
  logic [6:0]  a_mask;
  logic [10:0] a_addr;
  logic [55:0] a_wdata, a_rdata;

  logic        resetn_b, b_valid, b_we, b_ready, b_rsp_valid, b_init_done;
  logic [6:0]  b_mask;
  logic [8:0]  b_addr;
  logic [55:0] b_wdata, b_rdata;

  int checks;
  int failures;

  logic [55:0] model_mem [0:2047];
  bit          model_ready;
  logic        exp_rv;
  logic [55:0] exp_rd;

  sram_banked_gf180 #(.NUM_LANES(7), .NUM_BANKS(4), .ZERO_INIT(1)) u_dut_a (
    .clk(clk), .resetn(resetn_a), .req_valid(a_valid), .req_ready(a_ready),
    .req_we(a_we), .req_wmask(a_mask), .req_addr(a_addr), .req_wdata(a_wdata),
    .rsp_valid(a_rsp_valid), .rsp_rdata(a_rdata), .init_done(a_init_done)
  );

  sram_banked_gf180 #(.NUM_LANES(7), .NUM_BANKS(1), .ZERO_INIT(0)) u_dut_b (
    .clk(clk), .resetn(resetn_b), .req_valid(b_valid), .req_ready(b_ready),
    .req_we(b_we), .req_wmask(b_mask), .req_addr(b_addr), .req_wdata(b_wdata),
    .rsp_valid(b_rsp_valid), .rsp_rdata(b_rdata), .init_done(b_init_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [55:0] rand56();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    return t[55:0];
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 2048; i++) model_mem[i] = 56'd0;
  endtask

  // One clock of stimulus on instance A; records what the next sample should show.
  task automatic drive_a(input logic v, input logic we, input logic [6:0] m,
                         input logic [10:0] a, input logic [55:0] d);
    bit acc;
    a_valid = v; a_we = we; a_mask = m; a_addr = a; a_wdata = d;
    acc    = v && model_ready;
    exp_rv = acc && !we;
    if (exp_rv) exp_rd = model_mem[a];
    if (acc && we) begin
      for (int l = 0; l < NL; l++)
        if (m[l]) model_mem[a][8*l +: 8] = d[8*l +: 8];
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    resetn_a = 1'b0; resetn_b = 1'b0; model_ready = 0;
    a_valid = 0; a_we = 0; a_mask = '0; a_addr = '0; a_wdata = '0;
    b_valid = 0; b_we = 0; b_mask = '0; b_addr = '0; b_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (a_ready !== 1'b0) begin failures++; $display("FAIL reset_a_ready actual=%b required=0", a_ready); end
    checks++; if (a_init_done !== 1'b0) begin failures++; $display("FAIL reset_a_init_done actual=%b required=0", a_init_done); end
    checks++; if (a_rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_a_rsp_valid actual=%b required=0", a_rsp_valid); end
    checks++; if (b_ready !== 1'b1) begin failures++; $display("FAIL reset_b_ready actual=%b required=1", b_ready); end
    checks++; if (b_init_done !== 1'b1) begin failures++; $display("FAIL reset_b_init_done actual=%b required=1", b_init_done); end
    checks++; if (b_rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_b_rsp_valid actual=%b required=0", b_rsp_valid); end
  endtask

  task automatic test_reset_mid_init();
    resetn_a = 1'b1;
    for (int i = 0; i < 200; i++) drive_a(1'b1, 1'b0, 7'h7F, 11'h3FF, 56'd0);
    checks++; if (a_ready !== 1'b0) begin failures++; $display("FAIL midinit_ready actual=%b required=0", a_ready); end
    resetn_a = 1'b0;
    #1;
    checks++; if (a_init_done !== 1'b0) begin failures++; $display("FAIL midinit_reset_done actual=%b required=0", a_init_done); end
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Release reset with a read held on the port; ready must rise after exactly 512 edges.
  task automatic test_init_sequence();
    int rise_at;
    rise_at = 0;
    resetn_a = 1'b1;
    for (int i = 1; i <= 600 && rise_at == 0; i++) begin
      drive_a(1'b1, 1'b0, 7'h00, 11'h3FF, 56'd0);
      checks++;
      if (a_rsp_valid !== 1'b0) begin failures++; $display("FAIL init_no_accept cycle=%0d actual=%b required=0", i, a_rsp_valid); end
      if (a_ready === 1'b1) rise_at = i;
    end
    checks++; if (rise_at != 512) begin failures++; $display("FAIL init_latency actual=%0d required=512", rise_at); end
    checks++; if (a_init_done !== 1'b1) begin failures++; $display("FAIL init_done actual=%b required=1", a_init_done); end
    model_ready = 1; clear_model();
    drive_a(1'b1, 1'b0, 7'h00, 11'h3FF, 56'd0);
    checks++; if (a_rsp_valid !== 1'b1 || a_rdata !== 56'd0) begin failures++; $display("FAIL init_read_3ff actual=%b/%h required=1/0", a_rsp_valid, a_rdata); end
    drive_a(1'b1, 1'b0, 7'h00, 11'h7FF, 56'd0);
    checks++; if (a_rsp_valid !== 1'b1 || a_rdata !== 56'd0) begin failures++; $display("FAIL init_read_7ff actual=%b/%h required=1/0", a_rsp_valid, a_rdata); end
  endtask

  task automatic test_byte_mask();
    drive_a(1'b1, 1'b1, 7'h7F, 11'd5, 56'h11223344556677);
    checks++; if (a_rsp_valid !== 1'b0) begin failures++; $display("FAIL mask_write_rsp actual=%b required=0", a_rsp_valid); end
    drive_a(1'b1, 1'b1, 7'h01, 11'd5, 56'hAAAAAAAAAAAAAA);
    drive_a(1'b1, 1'b0, 7'h00, 11'd5, 56'd0);
    checks++; if (a_rsp_valid !== 1'b1 || a_rdata !== 56'h112233445566AA) begin failures++; $display("FAIL mask_read actual=%b/%h required=1/112233445566aa", a_rsp_valid, a_rdata); end
    drive_a(1'b0, 1'b0, 7'h00, 11'd5, 56'd0);
    checks++; if (a_rsp_valid !== 1'b0) begin failures++; $display("FAIL mask_rsp_one_cycle actual=%b required=0", a_rsp_valid); end
  endtask

  task automatic test_banking();
    logic [55:0] vals [4];
    int order [4];
    logic [1:0] bk;
    order = '{3, 0, 2, 1};
    for (int b = 0; b < 4; b++) begin
      vals[b] = rand56() ^ (56'd1 << b);
      bk = 2'(b);
      drive_a(1'b1, 1'b1, 7'h7F, {bk, 9'h010}, vals[b]);
    end
    for (int k = 0; k < 4; k++) begin
      bk = 2'(order[k]);
      drive_a(1'b1, 1'b0, 7'h00, {bk, 9'h010}, 56'd0);
      checks++;
      if (a_rsp_valid !== 1'b1 || a_rdata !== vals[order[k]]) begin
        failures++; $display("FAIL bank_read bank=%0d actual=%b/%h required=1/%h", order[k], a_rsp_valid, a_rdata, vals[order[k]]);
      end
    end
    drive_a(1'b0, 1'b0, 7'h00, 11'd0, 56'd0);
    checks++; if (a_rsp_valid !== 1'b0) begin failures++; $display("FAIL bank_idle_rsp actual=%b required=0", a_rsp_valid); end
  endtask

  task automatic test_raw();
    drive_a(1'b1, 1'b1, 7'h7F, 11'd7, 56'hFFFFFFFFFFFFFF);
    drive_a(1'b1, 1'b0, 7'h00, 11'd7, 56'd0);
    checks++; if (a_rsp_valid !== 1'b1 || a_rdata !== 56'hFFFFFFFFFFFFFF) begin failures++; $display("FAIL raw_full actual=%b/%h required=1/ffffffffffffff", a_rsp_valid, a_rdata); end
    drive_a(1'b1, 1'b1, 7'h55, 11'd7, 56'h0);
    drive_a(1'b1, 1'b0, 7'h00, 11'd7, 56'd0);
    checks++; if (a_rsp_valid !== 1'b1 || a_rdata !== 56'h00FF00FF00FF00) begin failures++; $display("FAIL raw_merge actual=%b/%h required=1/00ff00ff00ff00", a_rsp_valid, a_rdata); end
  endtask

  task automatic test_random();
    logic [1:0]  bk;
    logic [8:0]  row;
    logic        v, we;
    logic [6:0]  m;
    for (int i = 0; i < 400; i++) begin
      bk  = 2'($urandom_range(0, 3));
      row = 9'($urandom_range(0, 7));
      v   = ($urandom_range(0, 9) < 8);
      we  = $urandom_range(0, 1) == 1;
      m   = ($urandom_range(0, 7) == 0) ? 7'h00 : 7'($urandom());
      drive_a(v, we, m, {bk, row}, rand56());
      checks++;
      if (a_rsp_valid !== exp_rv || (exp_rv && a_rdata !== exp_rd)) begin
        failures++; $display("FAIL random_txn i=%0d actual=%b/%h required=%b/%h", i, a_rsp_valid, a_rdata, exp_rv, exp_rd);
      end
    end
  endtask

  // Reset lands while a response is on the port, then the clear must run again.
  task automatic test_reset_mid_run();
    drive_a(1'b1, 1'b1, 7'h7F, 11'd5, 56'h0123456789ABCD);
    drive_a(1'b1, 1'b0, 7'h00, 11'd5, 56'd0);
    checks++; if (a_rsp_valid !== 1'b1 || a_rdata !== 56'h0123456789ABCD) begin failures++; $display("FAIL run_pre_reset_read actual=%b/%h required=1/0123456789abcd", a_rsp_valid, a_rdata); end
    a_valid = 1'b0;
    resetn_a = 1'b0;
    #1;
    checks++; if (a_rsp_valid !== 1'b0) begin failures++; $display("FAIL run_reset_drops_rsp actual=%b required=0", a_rsp_valid); end
    checks++; if (a_ready !== 1'b0) begin failures++; $display("FAIL run_reset_ready actual=%b required=0", a_ready); end
    model_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    resetn_a = 1'b1;
    for (int i = 0; i < 512; i++) drive_a(1'b0, 1'b0, 7'h00, 11'd0, 56'd0);
    checks++; if (a_ready !== 1'b1) begin failures++; $display("FAIL rerun_ready actual=%b required=1", a_ready); end
    model_ready = 1; clear_model();
    drive_a(1'b1, 1'b0, 7'h00, 11'd5, 56'd0);
    checks++; if (a_rsp_valid !== 1'b1 || a_rdata !== 56'd0) begin failures++; $display("FAIL rerun_cleared actual=%b/%h required=1/0", a_rsp_valid, a_rdata); end
  endtask

  task automatic test_stall();
    logic [55:0] val;
    val = rand56();
    resetn_b = 1'b1;
    @(posedge clk); #1;
    checks++; if (b_ready !== 1'b1) begin failures++; $display("FAIL stall_ready actual=%b required=1", b_ready); end
    b_valid = 1'b1; b_we = 1'b1; b_mask = 7'h7F; b_addr = 9'd9; b_wdata = val;
    @(posedge clk); #1;
    checks++; if (b_rsp_valid !== 1'b0) begin failures++; $display("FAIL stall_write_rsp actual=%b required=0", b_rsp_valid); end
    b_mask = 7'h00; b_wdata = ~val;
    @(posedge clk); #1;
    b_we = 1'b0;
    @(posedge clk); #1;
    checks++; if (b_rsp_valid !== 1'b1 || b_rdata !== val) begin failures++; $display("FAIL stall_zero_mask actual=%b/%h required=1/%h", b_rsp_valid, b_rdata, val); end
    b_valid = 1'b0;
    @(posedge clk); #1;
    checks++; if (b_rsp_valid !== 1'b0) begin failures++; $display("FAIL stall_idle_rsp actual=%b required=0", b_rsp_valid); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_reset_mid_init();
    test_init_sequence();
    test_byte_mask();
    test_banking();
    test_raw();
    test_random();
    test_reset_mid_run();
    test_stall();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
